// File: rtl/test_accuracy_sequencer.sv
// Steps the 1-based test index through the whole test set and fires one inference per vector.
// Each prediction is compared with the label memory output, and the matches are counted to give the accuracy result.
module test_accuracy_sequencer #(
  parameter int NUM_TESTS = 750,
  parameter int LABEL_W   = 8,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic [CNT_W-1:0]   test_sel,
  input  logic [LABEL_W-1:0] label,
  output logic               net_start,
  input  logic               net_done,
  input  logic [LABEL_W-1:0] net_class,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   correct_count,
  output logic [CNT_W-1:0]   tested_count,
  output logic               last_match
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] LAST_SEL = CNT_W'(NUM_TESTS);

  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_testSel;
  logic [CNT_W-1:0]   r_correctCount;
  logic [CNT_W-1:0]   r_testedCount;
  logic               r_lastMatch;
  logic [LABEL_W-1:0] r_capturedClass;
  logic [LABEL_W-1:0] r_capturedLabel;

  logic w_match;
  logic w_lastVector;

  assign w_match      = (r_capturedClass == r_capturedLabel);
  assign w_lastVector = (r_testSel == LAST_SEL);

  // Abort freezes the index and counters. The reset index is 1 so the label memory address never leaves the valid range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_testSel       <= CNT_W'(1);
      r_correctCount  <= '0;
      r_testedCount   <= '0;
      r_lastMatch     <= 1'b0;
      r_capturedClass <= '0;
      r_capturedLabel <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state        <= S_ISSUE;
            r_testSel      <= CNT_W'(1);
            r_correctCount <= '0;
            r_testedCount  <= '0;
            r_lastMatch    <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_state <= abort ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (net_done) begin
            r_capturedClass <= net_class;
            r_capturedLabel <= label;
            r_state         <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_testedCount  <= r_testedCount + CNT_W'(1);
            r_correctCount <= r_correctCount + CNT_W'(w_match);
            r_lastMatch    <= w_match;
            if (w_lastVector) begin
              r_state <= S_DONE;
            end else begin
              r_testSel <= r_testSel + CNT_W'(1);
              r_state   <= S_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign test_sel      = r_testSel;
  assign net_start     = (r_state == S_ISSUE);
  assign busy          = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_CHECK);
  assign done          = (r_state == S_DONE);
  assign correct_count = r_correctCount;
  assign tested_count  = r_testedCount;
  assign last_match    = r_lastMatch;

endmodule

// File: tb/tb_test_accuracy_sequencer.sv
// Bench for test_accuracy_sequencer: a behavioural network/label model with a scoreboard, table-driven full passes,
// a randomized pass, and hand-written abort, spurious-event and async-reset sequences.
module tb_test_accuracy_sequencer;

  localparam int NUM     = 750;
  localparam int LABEL_W = 8;
  localparam int CNT_W   = 32;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic [CNT_W-1:0]   test_sel;
  logic [LABEL_W-1:0] label;
  logic               net_start;
  logic               net_done;
  logic [LABEL_W-1:0] net_class;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   correct_count;
  logic [CNT_W-1:0]   tested_count;
  logic               last_match;

  logic               modelDone    = 1'b0;
  logic [LABEL_W-1:0] modelClass   = '0;
  logic               spuriousDone = 1'b0;
  logic [LABEL_W-1:0] junkClass    = '0;

  int cfgLatency    = 1;
  int cfgWrongEvery = 0;
  int cfgHangAt     = 0;
  bit cfgRandom     = 1'b0;

  int sels[$];
  bit wrongs[$];
  int pulseCount = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int wrongEvery;
    int latency;
    int expCorrect;
    int expTested;
    int expLast;
    int expCycles;
  } passVec_t;

  function automatic logic [LABEL_W-1:0] labelOf(input int s);
    return LABEL_W'((s * 37 + 11) % 251);
  endfunction

  assign label     = labelOf(int'(test_sel));
  assign net_done  = modelDone | spuriousDone;
  assign net_class = modelDone ? modelClass : junkClass;

  test_accuracy_sequencer #(.NUM_TESTS(NUM), .LABEL_W(LABEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .test_sel(test_sel), .label(label), .net_start(net_start),
    .net_done(net_done), .net_class(net_class), .busy(busy), .done(done),
    .correct_count(correct_count), .tested_count(tested_count), .last_match(last_match)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (net_start) pulseCount++;

  // Network model: answers each inference request after a configurable latency and logs the request for the scoreboard.
  initial begin
    int sel;
    int lat;
    bit wrong;
    forever begin
      @(negedge clk);
      if (net_start && !rst) begin
        sel = int'(test_sel);
        if (sel != cfgHangAt) begin
          wrong = cfgRandom ? ($urandom_range(0, 3) == 0)
                            : (cfgWrongEvery != 0 && (sel % cfgWrongEvery) == 0);
          lat = cfgRandom ? int'($urandom_range(1, 6)) : cfgLatency;
          sels.push_back(sel);
          wrongs.push_back(wrong);
          repeat (lat) @(negedge clk);
          modelClass = wrong ? labelOf(sel) + LABEL_W'(1) : labelOf(sel);
          modelDone  = 1'b1;
          @(negedge clk);
          modelDone  = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit a);
    @(negedge clk);
    start = s;
    abort = a;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Runs until done; optionally injects a spurious net_done plus a start pulse in the CHECK cycle (latency 1 only).
  task automatic waitDone(input bit inject, output int cycles);
    int n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
      if (inject && net_start && (test_sel % 50 == 0)) begin
        @(negedge clk);
        @(negedge clk);
        n += 2;
        junkClass    = label;
        spuriousDone = 1'b1;
        start        = 1'b1;
        @(negedge clk);
        n++;
        spuriousDone = 1'b0;
        start        = 1'b0;
      end
    end
    cycles = n;
    checkOutput("doneReached", longint'(done), 1);
  endtask

  // Scoreboard comparison of a finished pass against the requests logged since base.
  task automatic checkPass(input int base, input int pulseBase);
    int nT = sels.size() - base;
    int expC = 0;
    int seqErr = 0;
    int expLast = 0;
    for (int i = 0; i < nT; i++) begin
      if (!wrongs[base + i]) expC++;
      if (sels[base + i] != i + 1) seqErr++;
    end
    if (nT > 0) expLast = wrongs[base + nT - 1] ? 0 : 1;
    checkOutput("modelTested", longint'(tested_count), nT);
    checkOutput("modelCorrect", longint'(correct_count), expC);
    checkOutput("modelLastMatch", longint'(last_match), expLast);
    checkOutput("indexSweep", seqErr, 0);
    checkOutput("netStartPulses", pulseCount - pulseBase, NUM);
    checkOutput("finalTestSel", longint'(test_sel), NUM);
    checkOutput("busyAtDone", longint'(busy), 0);
  endtask

  initial begin
    passVec_t vecs[4];
    int base;
    int pulseBase;
    int cycles;
    int n;

    vecs[0] = '{wrongEvery: 0,  latency: 5, expCorrect: 750, expTested: 750, expLast: 1, expCycles: -1};
    vecs[1] = '{wrongEvery: 10, latency: 5, expCorrect: 675, expTested: 750, expLast: 0, expCycles: -1};
    vecs[2] = '{wrongEvery: 1,  latency: 1, expCorrect: 0,   expTested: 750, expLast: 0, expCycles: 2250};
    vecs[3] = '{wrongEvery: 7,  latency: 2, expCorrect: 643, expTested: 750, expLast: 1, expCycles: -1};

    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    #3;
    checkOutput("rstTestSel", longint'(test_sel), 1);
    checkOutput("rstBusy", longint'(busy), 0);
    checkOutput("rstDone", longint'(done), 0);
    checkOutput("rstNetStart", longint'(net_start), 0);
    checkOutput("rstCorrect", longint'(correct_count), 0);
    checkOutput("rstTested", longint'(tested_count), 0);
    checkOutput("rstLastMatch", longint'(last_match), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      cfgRandom     = 1'b0;
      cfgWrongEvery = vecs[v].wrongEvery;
      cfgLatency    = vecs[v].latency;
      base          = sels.size();
      pulseBase     = pulseCount;
      applyStimulus(1'b1, 1'b0);
      waitDone(1'b0, cycles);
      checkOutput($sformatf("vec%0dCorrect", v), longint'(correct_count), vecs[v].expCorrect);
      checkOutput($sformatf("vec%0dTested", v), longint'(tested_count), vecs[v].expTested);
      checkOutput($sformatf("vec%0dLastMatch", v), longint'(last_match), vecs[v].expLast);
      if (vecs[v].expCycles >= 0)
        checkOutput($sformatf("vec%0dCycles", v), cycles, vecs[v].expCycles);
      checkPass(base, pulseBase);
    end

    $display("[TB] randomized pass");
    cfgRandom = 1'b1;
    base      = sels.size();
    pulseBase = pulseCount;
    applyStimulus(1'b1, 1'b0);
    waitDone(1'b0, cycles);
    checkPass(base, pulseBase);
    cfgRandom = 1'b0;

    $display("[TB] abort in WAIT of vector 100 with coincident net_done");
    cfgLatency    = 1;
    cfgWrongEvery = 0;
    cfgHangAt     = 100;
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (!(busy && !net_start && test_sel == 100) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachedWait100", longint'(test_sel), 100);
    junkClass    = label;
    abort        = 1'b1;
    spuriousDone = 1'b1;
    @(negedge clk);
    abort        = 1'b0;
    spuriousDone = 1'b0;
    checkOutput("abortBusy", longint'(busy), 0);
    checkOutput("abortDone", longint'(done), 0);
    checkOutput("abortTested", longint'(tested_count), 99);
    checkOutput("abortCorrect", longint'(correct_count), 99);
    checkOutput("abortTestSel", longint'(test_sel), 100);

    junkClass    = label;
    spuriousDone = 1'b1;
    @(negedge clk);
    spuriousDone = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idleSpuriousTested", longint'(tested_count), 99);
    checkOutput("idleNetStart", longint'(net_start), 0);

    cfgHangAt = 0;
    base      = sels.size();
    pulseBase = pulseCount;
    applyStimulus(1'b1, 1'b1);
    checkOutput("restartNetStart", longint'(net_start), 1);
    checkOutput("restartTestSel", longint'(test_sel), 1);
    checkOutput("restartTested", longint'(tested_count), 0);
    checkOutput("restartCorrect", longint'(correct_count), 0);
    checkOutput("restartLastMatch", longint'(last_match), 0);
    waitDone(1'b1, cycles);
    checkOutput("injectCorrect", longint'(correct_count), 750);
    checkPass(base, pulseBase);

    $display("[TB] async reset mid-WAIT");
    cfgLatency = 5;
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (!(net_start && test_sel == 3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachedIssue3", longint'(test_sel), 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arstTestSel", longint'(test_sel), 1);
    checkOutput("arstBusy", longint'(busy), 0);
    checkOutput("arstNetStart", longint'(net_start), 0);
    checkOutput("arstCorrect", longint'(correct_count), 0);
    checkOutput("arstTested", longint'(tested_count), 0);
    checkOutput("arstDone", longint'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("postResetTested", longint'(tested_count), 0);
    checkOutput("postResetBusy", longint'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
